bcd_to_binary: RTL

Sequential BCD-to-binary converter using reverse double dabble (shift right, subtract-3 correction). It is the inverse of the team's multiplier/double-dabble block: it accepts a packed BCD value in the same digit format that block produces and returns the 2N-bit binary equivalent. It feeds operands entered in decimal into the binary multiplier datapath, with an overflow flag. It uses the same level-`start` / held-`finish` handshake as the multiplier.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_to_binary_if.sv | 26 ++
 rtl/bcd_sub3_correct.sv | 20 ++
 rtl/bcd_to_binary.sv | 137 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encoding, digit constants
// and the default digit-count helper.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int unsigned BCD_MAX     = 9;
   localparam int unsigned CORR_THRESH = 8;
   localparam int unsigned CORR_SUB    = 3;

   // Enough decimal digits to represent any 2n-bit binary value.
   function automatic int bcd_digits(input int n);
      return (2 * n) / 3 + 1;
   endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Level-start / held-finish handshake and data bus of the BCD-to-binary converter.
interface bcd_to_binary_if
   import bcd_pkg::*;
#(
   parameter int N      = 8,
   parameter int DIGITS = bcd_digits(N)
);

   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic [2*N-1:0]        out;
   logic                  finish;
   logic                  ovf;
   logic                  err;

   modport master (
      output start, bcd_in,
      input  out, finish, ovf, err
   );

   modport slave (
      input  start, bcd_in,
      output out, finish, ovf, err
   );

endinterface

// File: rtl/bcd_sub3_correct.sv
// Reverse double-dabble digit correction: every BCD digit >= 8 has 3 subtracted.
module bcd_sub3_correct
   import bcd_pkg::*;
#(
   parameter int DIGITS = 6
) (
   input  logic [4*DIGITS-1:0] bcd_i,
   output logic [4*DIGITS-1:0] bcd_o
);

   always_comb begin
      bcd_o = bcd_i;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_i[4*i +: 4] >= 4'(CORR_THRESH)) begin
            bcd_o[4*i +: 4] = bcd_i[4*i +: 4] - 4'(CORR_SUB);
         end
      end
   end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double dabble, one bit per cycle).
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_binary
   import bcd_pkg::*;
#(
   parameter int N      = 8,
   parameter int DIGITS = bcd_digits(N)
) (
   input  logic                    clk,
   input  logic                    reset,
   bcd_to_binary_if.slave          bus
);

   localparam int BW = 4 * DIGITS;
   localparam int OW = 2 * N;
   localparam int CW = $clog2(BW + 1);

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] SHIFT = ST_SHIFT;
   localparam logic [1:0] DONE  = ST_DONE;

   logic [1:0]    state_q,  state_d;
   logic [BW-1:0] bcd_q,    bcd_d;
   logic [BW-1:0] bin_q,    bin_d;
   logic [CW-1:0] cnt_q,    cnt_d;
   logic [OW-1:0] out_q,    out_d;
   logic          finish_q, finish_d;
   logic          ovf_q,    ovf_d;
   logic          err_q,    err_d;

   logic [BW-1:0] bcd_sh, bcd_corr, bin_sh;
   logic [OW-1:0] out_load;
   logic          ovf_calc;
   logic          digit_bad;

   // The BCD LSB falls into the binary MSB; correction applies after the shift.
   assign bcd_sh = {1'b0, bcd_q[BW-1:1]};
   assign bin_sh = {bcd_q[0], bin_q[BW-1:1]};

   bcd_sub3_correct #(.DIGITS(DIGITS)) u_corr (
      .bcd_i (bcd_sh),
      .bcd_o (bcd_corr)
   );

   assign out_load = OW'(bin_q);

   generate
      if (BW > OW) begin : g_ovf
         assign ovf_calc = |bin_q[BW-1:OW];
      end else begin : g_no_ovf
         assign ovf_calc = 1'b0;
      end
   endgenerate

`ifdef BCD_DIGIT_CHECK_EN
   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.bcd_in[4*i +: 4] > 4'(BCD_MAX)) digit_bad = 1'b1;
      end
   end
`else
   assign digit_bad = 1'b0;
`endif

   always_comb begin
      // NOTE: every next-state signal defaults to its register, so no path infers a latch.
      state_d  = state_q;
      bcd_d    = bcd_q;
      bin_d    = bin_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      finish_d = finish_q;
      ovf_d    = ovf_q;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               bcd_d    = bus.bcd_in;
               bin_d    = '0;
               cnt_d    = CW'(BW);
               finish_d = 1'b0;
               ovf_d    = 1'b0;
               err_d    = digit_bad;
               state_d  = digit_bad ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            bcd_d = bcd_corr;
            bin_d = bin_sh;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            if (!finish_q) begin
               finish_d = 1'b1;
               out_d    = err_q ? '0   : out_load;
               ovf_d    = err_q ? 1'b0 : ovf_calc;
            end else if (!bus.start) begin
               finish_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         bcd_q    <= '0;
         bin_q    <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         finish_q <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bcd_q    <= bcd_d;
         bin_q    <= bin_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         finish_q <= finish_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign bus.out    = out_q;
   assign bus.finish = finish_q;
   assign bus.ovf    = ovf_q;
   assign bus.err    = err_q;

endmodule
